// File: rtl/tdm_demux4.sv
// 1-to-4 TDM demultiplexer: rebuilds four MSB-first channel words from a framed serial stream.
// Latency 1 clk from last-bit sample to dout/dout_valid; in_en=0 holds all state. Optional TDM_DEMUX_PARITY_EN adds a parity bit per slot.
module tdm_demux4 #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_en,
    input  logic                 din,
    input  logic                 sync,
    output logic [4*WIDTH-1:0]   dout,
    output logic [3:0]           dout_valid,
    output logic                 locked,
`ifdef TDM_DEMUX_PARITY_EN
    output logic                 par_err,
`endif
    output logic                 sync_err
);

`ifdef TDM_DEMUX_PARITY_EN
    localparam int SLOT_BITS = WIDTH + 1;
`else
    localparam int SLOT_BITS = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(SLOT_BITS - 1);

    typedef enum logic {HUNT, LOCK} state_t;

    state_t           state;
    logic [CW-1:0]    bit_cnt;
    logic [1:0]       slot;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] word;
    logic             word_ok;
    logic             misaligned;

    // With parity the data bits are already in shreg when the parity bit arrives.
`ifdef TDM_DEMUX_PARITY_EN
    assign word    = shreg;
    assign word_ok = ~(^shreg ^ din);
`else
    assign word    = {shreg[WIDTH-2:0], din};
    assign word_ok = 1'b1;
`endif

    assign misaligned = sync && ((bit_cnt != '0) || (slot != 2'd0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HUNT;
            bit_cnt    <= '0;
            slot       <= 2'd0;
            shreg      <= '0;
            dout       <= '0;
            dout_valid <= 4'b0000;
            locked     <= 1'b0;
            sync_err   <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            par_err    <= 1'b0;
`endif
        end else begin
            dout_valid <= 4'b0000;
            sync_err   <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            par_err    <= 1'b0;
`endif
            if (in_en) begin
                shreg <= {shreg[WIDTH-2:0], din};
                case (state)
                    HUNT: begin
                        if (sync) begin
                            state   <= LOCK;
                            locked  <= 1'b1;
                            bit_cnt <= CW'(1);
                            slot    <= 2'd0;
                        end
                    end
                    default: begin
                        if (misaligned) begin
                            // Drop the partial word and treat this bit as slot 0, bit 0.
                            sync_err <= 1'b1;
                            bit_cnt  <= CW'(1);
                            slot     <= 2'd0;
                        end else if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            slot    <= slot + 2'd1;
                            if (word_ok) begin
                                dout[slot*WIDTH +: WIDTH] <= word;
                                dout_valid                <= 4'b0001 << slot;
                            end
`ifdef TDM_DEMUX_PARITY_EN
                            else begin
                                par_err <= 1'b1;
                            end
`endif
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4 at WIDTH=4; parity scenario compiles in with TDM_DEMUX_PARITY_EN.
module tb_tdm_demux4;
    localparam int W = 4;
`ifdef TDM_DEMUX_PARITY_EN
    localparam int SB = W + 1;
`else
    localparam int SB = W;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_en = 1'b0;
    logic           din = 1'b0;
    logic           sync = 1'b0;
    logic [4*W-1:0] dout;
    logic [3:0]     dout_valid;
    logic           locked;
    logic           sync_err;
`ifdef TDM_DEMUX_PARITY_EN
    logic           par_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [4*W-1:0] exp_dout = '0;

    tdm_demux4 #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_en      (in_en),
        .din        (din),
        .sync       (sync),
        .dout       (dout),
        .dout_valid (dout_valid),
        .locked     (locked),
`ifdef TDM_DEMUX_PARITY_EN
        .par_err    (par_err),
`endif
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    task automatic step(input logic d, input logic s, input logic e);
        din = d; sync = s; in_en = e;
        @(posedge clk);
        #1;
    endtask

    // Sends one slot MSB first (plus a correct parity bit when enabled).
    task automatic send_word(input logic [W-1:0] w, input int lane, input logic sync_first,
                             input bit gaps, input bit strobe, input bit err_first);
        logic [3:0] exp_v;
        logic       b;
        for (int i = 0; i < SB; i++) begin
            b = (i < W) ? w[W-1-i] : ^w;
            step(b, sync_first && (i == 0), 1'b1);
            exp_v = 4'b0000;
            if (i == SB - 1 && strobe) begin
                exp_v = 4'b0001 << lane;
                exp_dout[lane*W +: W] = w;
            end
            n_cmp++;
            if (dout_valid !== exp_v) begin
                n_bad++;
                $display("FAIL valid lane%0d bit%0d: got %b want %b", lane, i, dout_valid, exp_v);
            end
            n_cmp++;
            if (sync_err !== (err_first && i == 0)) begin
                n_bad++;
                $display("FAIL sync_err lane%0d bit%0d: got %b want %b", lane, i, sync_err, err_first && i == 0);
            end
            if (i == 0 && sync_first) begin
                n_cmp++;
                if (locked !== 1'b1) begin
                    n_bad++;
                    $display("FAIL locked after sync: got %b want 1", locked);
                end
            end
            if (gaps) begin
                step(1'b1, 1'b1, 1'b0);
                n_cmp++;
                if (dout_valid !== 4'b0000 || sync_err !== 1'b0) begin
                    n_bad++;
                    $display("FAIL hold lane%0d bit%0d: valid %b err %b want 0000/0", lane, i, dout_valid, sync_err);
                end
            end
        end
        n_cmp++;
        if (dout !== exp_dout) begin
            n_bad++;
            $display("FAIL dout lane%0d: got %h want %h", lane, dout, exp_dout);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        rst = 1'b0;
        n_cmp++;
        if (dout !== '0 || dout_valid !== 4'b0 || locked !== 1'b0 || sync_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: dout %h valid %b locked %b err %b want 0", dout, dout_valid, locked, sync_err);
        end
        for (int i = 0; i < 6; i++) begin
            step(i[0], 1'b0, 1'b1);
            n_cmp++;
            if (dout !== '0 || dout_valid !== 4'b0 || locked !== 1'b0) begin
                n_bad++;
                $display("FAIL hunt bit%0d: dout %h valid %b locked %b want 0", i, dout, dout_valid, locked);
            end
        end
    endtask

    task automatic test_lock_stream;
        send_word(4'hA, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        send_word(4'h5, 1, 1'b0, 1'b0, 1'b1, 1'b0);
        send_word(4'hC, 2, 1'b0, 1'b0, 1'b1, 1'b0);
        send_word(4'h3, 3, 1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (dout !== 16'h3C5A) begin
            n_bad++;
            $display("FAIL frame1: got %h want 3c5a", dout);
        end
    endtask

    task automatic test_gapped;
        dut_clear_check();
        send_word(4'hA, 0, 1'b1, 1'b1, 1'b1, 1'b0);
        send_word(4'h5, 1, 1'b0, 1'b1, 1'b1, 1'b0);
        send_word(4'hC, 2, 1'b0, 1'b1, 1'b1, 1'b0);
        send_word(4'h3, 3, 1'b0, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (dout !== 16'h3C5A) begin
            n_bad++;
            $display("FAIL gapped frame: got %h want 3c5a", dout);
        end
    endtask

    task automatic dut_clear_check;
        n_cmp++;
        if (locked !== 1'b1) begin
            n_bad++;
            $display("FAIL locked held: got %b want 1", locked);
        end
    endtask

    task automatic test_second_frame;
        send_word(4'h1, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        send_word(4'h2, 1, 1'b0, 1'b0, 1'b1, 1'b0);
        send_word(4'h3, 2, 1'b0, 1'b0, 1'b1, 1'b0);
        send_word(4'h4, 3, 1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (dout !== 16'h4321) begin
            n_bad++;
            $display("FAIL frame2: got %h want 4321", dout);
        end
    endtask

    task automatic test_misaligned_sync;
        send_word(4'h9, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_word(4'h8, 1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        n_cmp++;
        if (dout_valid !== 4'b0000 || sync_err !== 1'b0) begin
            n_bad++;
            $display("FAIL slot2 bit0: valid %b err %b want 0000/0", dout_valid, sync_err);
        end
        send_word(4'hF, 0, 1'b1, 1'b0, 1'b1, 1'b1);
        send_word(4'hE, 1, 1'b0, 1'b0, 1'b1, 1'b0);
        send_word(4'hD, 2, 1'b0, 1'b0, 1'b1, 1'b0);
        send_word(4'hB, 3, 1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (dout !== 16'hBDEF) begin
            n_bad++;
            $display("FAIL realign: got %h want bdef", dout);
        end
    endtask

`ifdef TDM_DEMUX_PARITY_EN
    task automatic test_parity;
        logic [4:0] bad_slot;
        logic [4:0] good_slot;
        bad_slot  = 5'b10101;
        good_slot = 5'b01100;
        for (int i = 0; i < 5; i++) step(bad_slot[4-i], 1'b0, 1'b1);
        n_cmp++;
        if (par_err !== 1'b1 || dout_valid !== 4'b0000 || dout !== 16'hBDEF) begin
            n_bad++;
            $display("FAIL bad parity: par_err %b valid %b dout %h want 1/0000/bdef", par_err, dout_valid, dout);
        end
        for (int i = 0; i < 5; i++) step(good_slot[4-i], 1'b0, 1'b1);
        n_cmp++;
        if (par_err !== 1'b0 || dout_valid !== 4'b0010 || dout[7:4] !== 4'h6) begin
            n_bad++;
            $display("FAIL good parity: par_err %b valid %b lane1 %h want 0/0010/6", par_err, dout_valid, dout[7:4]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_lock_stream();
        test_gapped();
        test_second_frame();
        test_misaligned_sync();
`ifdef TDM_DEMUX_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
